// File: rtl/on_board_switch_debouncer.sv
// Per-bit 2-flop synchroniser followed by a debounce counter; drives a clean
// registered level into the switches PIO plus a one-cycle change strobe.
module on_board_switch_debouncer #(
  parameter int                 WIDTH           = 8,
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0]   RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_changed
);

  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= RESET_VALUE;
      sync2      <= RESET_VALUE;
      sw_out     <= RESET_VALUE;
      sw_changed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_out[i]) begin
          // any return to the accepted level forfeits all accumulated credit
          cnt[i]        <= '0;
          sw_changed[i] <= 1'b0;
        end else if (cnt[i] == CNT_MAX) begin
          sw_out[i]     <= sync2[i];
          cnt[i]        <= '0;
          sw_changed[i] <= 1'b1;
        end else begin
          cnt[i]        <= cnt[i] + 1'b1;
          sw_changed[i] <= 1'b0;
        end
      end
    end
  end

endmodule
